alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one combinational 8-bit ALU between two independent requesters (port 0, port 1).
- Each requester sends operands and an opcode with a valid/ready handshake, and gets back result, zero and carry with a valid/ready handshake.
- Round-robin arbitration, one operation in flight at a time, registered operands and results.
- Sits between two datapath clients (e.g. a sequencer and a test/debug port) and the shared ALU.

Parameters:
- WIDTH, 8, operand/result width in bits; applies to the ALU instance and all data ports.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  arbiter accepts requester 0's operation this cycle.
- req0_a  input  WIDTH  requester 0 operand a.
- req0_b  input  WIDTH  requester 0 operand b.
- req0_sel  input  3  requester 0 opcode.
- rsp0_valid  output  1  result for requester 0 is available.
- rsp0_ready  input  1  requester 0 accepts its result.
- req1_valid, req1_ready, req1_a, req1_b, req1_sel, rsp1_valid, rsp1_ready  same as port 0, for requester 1.
- rsp_result  output  WIDTH  registered result (shared by both response ports).
- rsp_zero  output  1  registered zero flag.
- rsp_carry  output  1  registered carry/borrow flag.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Opcode map (3-bit sel):
  - 000 ADD: {carry,result} = a+b.
  - 001 SUB: {carry,result} = a-b, so carry is 1 on borrow.
  - 010 AND, 011 OR, 100 XOR.
  - 101 SLT: unsigned, result = 1 if a<b else 0.
  - 110 SHL: a<<1. 111 SHR: a>>1.
  - carry is 0 for every op except ADD and SUB.
  - zero = (result == 0).
- FSM states:
  - IDLE:
    - Grant is computed combinationally from req valids and the priority pointer `prio`.
    - If only one requester is valid, it wins.
    - If both are valid, the requester equal to `prio` wins.
    - reqN_ready = (state==IDLE) && grant==N. Ready is never high for both ports. Ready does not depend on rspN_ready.
    - On a handshake: latch a, b, sel and the grant index `owner`, then go to EXEC.
  - EXEC:
    - Drive the ALU from the latched operands.
    - Register result/zero/carry into the rsp_* registers.
    - Go to RESP.
  - RESP:
    - rsp<owner>_valid is high; the other rsp valid is low.
    - rsp_result/zero/carry stay stable until rsp<owner>_ready is high.
    - On that handshake: go to IDLE and set prio = ~owner.
- Latency and throughput:
  - Request handshake in cycle N gives rspN_valid high from cycle N+2.
  - Minimum 3 cycles per operation. No new request is accepted while in EXEC or RESP.
- Fairness: under continuous requests from both ports, grants alternate 0,1,0,1. A lone requester may be granted back to back.
- The `prio` pointer changes only on response completion, not on grant.
- A request that is valid but not granted must be held stable by the requester (standard valid/ready). The arbiter does not latch it.
- rspN_ready while rspN_valid is low is ignored.
- Reset, including mid-operation:
  - state=IDLE, prio=0, owner=0.
  - rsp_result=0, rsp_zero=0, rsp_carry=0.
  - All valids and readies low, busy=0.
  - Any in-flight operation is dropped with no response.
  - Ready outputs are low during the cycle rst is high.
- An undefined state decodes to IDLE.

Decomposition:
- Shared package `alu_pkg`:
  - opcode localparams OP_ADD..OP_SHR (3'b000..3'b111).
  - FSM state encoding (ST_IDLE, ST_EXEC, ST_RESP, 2 bits).
- Sub-module: the existing combinational `alu` (parameter WIDTH), instantiated once and fed from the latched operand registers.
- Arbitration and FSM stay in alu_arbiter. No separate arbiter sub-module for only two ports.

Test Plan:
- Reset check: hold rst 2 cycles, then release with no requests → busy=0, both ready=0, both rsp valid=0, rsp_result=0.
- Single ADD: req0 a=200, b=100, sel=000, rsp0_ready=1 → rsp0_valid at N+2 with result=44, carry=1, zero=0, then busy=0.
- Flags: req1 SUB 5-5 → result=0, zero=1, carry=0. Then SUB 3-5 → result=254, carry=1. Then SLT 3,5 → result=1, carry=0.
- Contention: both valid continuously, 4 ops each → grant order 0,1,0,1,0,1,0,1. The req ready signals are never both high.
- Backpressure: rsp0_ready low for 4 cycles → rsp0_valid and rsp_result stable throughout, req1_ready stays 0. Raising rsp0_ready gives IDLE next cycle, then req1 is granted.
- Mid-op reset: assert rst in EXEC, then separately in RESP → next cycle is IDLE with no rsp valid, and the next grant goes to port 0 when both are valid.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode map and arbiter FSM state encoding shared by alu and alu_arbiter
package alu_pkg;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;
  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_EXEC = 2'b01, ST_RESP = 2'b10} state_t;
endpackage

// File: rtl/alu.sv
// alu: combinational WIDTH-bit ALU; in a, b, sel; out result, zero, carry (carry = ADD carry-out / SUB borrow)
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry
);
  logic [WIDTH:0] sum, diff;
  assign sum  = {1'b0, a} + {1'b0, b};
  // top bit of the widened difference is set exactly when a < b (borrow)
  assign diff = {1'b0, a} - {1'b0, b};
  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (sel)
      OP_ADD:  {carry, result} = sum;
      OP_SUB:  {carry, result} = diff;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLT:  result = WIDTH'(a < b);
      OP_SHL:  result = a << 1;
      OP_SHR:  result = a >> 1;
      default: result = '0;
    endcase
  end
  assign zero = result == '0;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one ALU by two valid/ready requesters; ports clk, rst, req0/1_{valid,ready,a,b,sel}, rsp0/1_{valid,ready}, rsp_{result,zero,carry}, busy
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_sel,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_sel,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_carry,
  output logic             busy
);
  state_t state, state_nx;
  logic prio, owner, grant, idle, hs, done;
  logic [WIDTH-1:0] a_q, b_q, alu_result;
  logic [2:0] sel_q;
  logic alu_zero, alu_carry;
  // the unused encoding behaves as IDLE
  assign idle = !(state == ST_EXEC || state == ST_RESP);
  assign grant = (req0_valid && req1_valid) ? prio : req1_valid;
  assign req0_ready = idle && !rst && req0_valid && !grant;
  assign req1_ready = idle && !rst && req1_valid && grant;
  assign hs = req0_ready || req1_ready;
  assign rsp0_valid = state == ST_RESP && !owner;
  assign rsp1_valid = state == ST_RESP && owner;
  assign done = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
  assign busy = !idle;
  always_comb begin
    state_nx = ST_IDLE;
    state_nx = hs ? ST_EXEC : state == ST_EXEC ? ST_RESP : (state == ST_RESP && !done) ? ST_RESP : ST_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      prio       <= 1'b0;
      owner      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      sel_q      <= OP_ADD;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_carry  <= 1'b0;
    end else begin
      if (hs) begin
        a_q   <= grant ? req1_a : req0_a;
        b_q   <= grant ? req1_b : req0_b;
        sel_q <= grant ? req1_sel : req0_sel;
        owner <= grant;
      end
      if (state == ST_EXEC) begin
        rsp_result <= alu_result;
        rsp_zero   <= alu_zero;
        rsp_carry  <= alu_carry;
      end
      // priority moves only when a response completes
      if (done) prio <= !owner;
    end
  end
  alu #(.WIDTH(WIDTH)) u_alu (
    .a      (a_q),
    .b      (b_q),
    .sel    (sel_q),
    .result (alu_result),
    .zero   (alu_zero),
    .carry  (alu_carry)
  );
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a behavioural model
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic v[2], rdy[2];
  logic [7:0] a[2], b[2];
  logic [2:0] s[2];
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_zero, rsp_carry, busy;
  logic [7:0] rsp_result;
  int total = 0;
  int bad = 0;
  int pref = 0;
  always #5 clk = ~clk;
  alu_arbiter #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (v[0]),
    .req0_ready (req0_ready),
    .req0_a     (a[0]),
    .req0_b     (b[0]),
    .req0_sel   (s[0]),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rdy[0]),
    .req1_valid (v[1]),
    .req1_ready (req1_ready),
    .req1_a     (a[1]),
    .req1_b     (b[1]),
    .req1_sel   (s[1]),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rdy[1]),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_carry  (rsp_carry),
    .busy       (busy)
  );
  function automatic logic [8:0] alu_ref(input int x, input int y, input int op);
    int r;
    bit c;
    c = 1'b0;
    case (op)
      0: begin r = x + y; c = r > 255; end
      1: begin r = x - y; c = x < y; end
      2: r = x & y;
      3: r = x | y;
      4: r = x ^ y;
      5: r = (x < y) ? 1 : 0;
      6: r = x * 2;
      7: r = x / 2;
      default: r = 0;
    endcase
    return {c, 8'(r & 255)};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask
  task automatic rnd(input int p);
    a[p] = 8'($urandom);
    b[p] = 8'($urandom);
    s[p] = 3'($urandom);
  endtask
  task automatic wait_grant();
    int n = 0;
    while (!(req0_ready || req1_ready) && n < 8) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("grant_seen", 32'(req0_ready || req1_ready), 1);
  endtask
  task automatic serve(input int stall, input bit drop);
    int w;
    logic [8:0] want;
    w = (v[0] && v[1]) ? pref : (v[1] ? 1 : 0);
    want = alu_ref(a[w], b[w], s[w]);
    rdy[w] = (stall == 0);
    rdy[1-w] = 1'($urandom);
    #1;
    wait_grant();
    chk("one_ready", 32'(req0_ready && req1_ready), 0);
    chk("winner", 32'(req1_ready), 32'(w));
    @(negedge clk);
    if (drop) v[w] = 1'b0;
    else rnd(w);
    #1;
    chk("exec_busy", 32'(busy), 1);
    chk("exec_no_rsp", 32'(rsp0_valid || rsp1_valid), 0);
    @(negedge clk);
    #1;
    chk("rsp_valid", {rsp1_valid, rsp0_valid}, w == 1 ? 2 : 1);
    chk("result", 32'(rsp_result), 32'(want[7:0]));
    chk("zero", 32'(rsp_zero), 32'(want[7:0] == 0));
    chk("carry", 32'(rsp_carry), 32'(want[8]));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      #1;
      chk("stall_valid", {rsp1_valid, rsp0_valid}, w == 1 ? 2 : 1);
      chk("stall_result", 32'(rsp_result), 32'(want[7:0]));
      chk("stall_no_ready", 32'(req0_ready || req1_ready), 0);
    end
    rdy[w] = 1'b1;
    @(negedge clk);
    #1;
    chk("idle_after", 32'(busy), 0);
    chk("no_rsp_after", 32'(rsp0_valid || rsp1_valid), 0);
    pref = 1 - w;
  endtask
  task automatic abort(input int depth);
    rdy[0] = 1'b0;
    rdy[1] = 1'b0;
    #1;
    wait_grant();
    chk("abort_winner", 32'(req1_ready), 32'(pref));
    repeat (depth) @(negedge clk);
    #1;
    chk("abort_busy", 32'(busy), 1);
    chk("abort_rsp_state", 32'(rsp0_valid || rsp1_valid), 32'(depth == 2));
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_no_rsp", 32'(rsp0_valid || rsp1_valid), 0);
    chk("rst_no_ready", 32'(req0_ready || req1_ready), 0);
    chk("rst_result", 32'(rsp_result), 0);
    rst = 1'b0;
    pref = 0;
    #1;
    chk("post_rst_grant0", {req1_ready, req0_ready}, 1);
  endtask
  initial begin
    for (int p = 0; p < 2; p++) begin
      v[p] = 1'b0;
      rdy[p] = 1'b0;
      a[p] = '0;
      b[p] = '0;
      s[p] = '0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_ready", {req1_ready, req0_ready}, 0);
    chk("reset_rsp", {rsp1_valid, rsp0_valid}, 0);
    chk("reset_result", 32'(rsp_result), 0);
    v[0] = 1'b1; a[0] = 8'd200; b[0] = 8'd100; s[0] = 3'd0;
    serve(0, 1'b1);
    v[1] = 1'b1; a[1] = 8'd5; b[1] = 8'd5; s[1] = 3'd1;
    serve(0, 1'b1);
    v[1] = 1'b1; a[1] = 8'd3; b[1] = 8'd5; s[1] = 3'd1;
    serve(0, 1'b1);
    v[1] = 1'b1; a[1] = 8'd3; b[1] = 8'd5; s[1] = 3'd5;
    serve(0, 1'b1);
    pref = 0;
    v[0] = 1'b1; rnd(0);
    serve(0, 1'b1);
    v[0] = 1'b1; v[1] = 1'b1; rnd(0); rnd(1);
    for (int k = 0; k < 8; k++) serve(0, 1'b0);
    serve(4, 1'b0);
    serve(0, 1'b1);
    v[0] = 1'b1; v[1] = 1'b0;
    serve(0, 1'b1);
    v[0] = 1'b1; v[1] = 1'b1;
    abort(1);
    serve(0, 1'b0);
    abort(2);
    serve(0, 1'b0);
    v[0] = 1'b0; v[1] = 1'b0;
    for (int k = 0; k < 30; k++) begin
      for (int p = 0; p < 2; p++)
        if (!v[p]) begin
          v[p] = 1'($urandom);
          rnd(p);
        end
      if (!v[0] && !v[1]) v[$urandom_range(0, 1)] = 1'b1;
      serve($urandom_range(0, 2), 1'($urandom));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
